// File: rtl/psum_accum_pkg.sv
// Shared types and constants for the partial-sum accumulator and its packing stage.
// No logic: widths, saturation limits, FSM encoding and a sign-extension helper.
// Not applicable (package only).
package psum_accum_pkg;

    // Width of a stored partial sum and of a neuron result
    localparam int PSUM_W = 16;
    // Internal accumulator width; wide enough for 255 full-scale taps plus one psum
    localparam int ACC_W  = 24;

    // Saturation limits expressed at accumulator width
    localparam logic signed [ACC_W-1:0] SAT_MAX = 24'sd32767;
    localparam logic signed [ACC_W-1:0] SAT_MIN = -24'sd32768;

    // Per-neuron sequencing
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ACC   = 3'd1,
        ST_FETCH = 3'd2,
        ST_MERGE = 3'd3,
        ST_EMIT  = 3'd4
    } state_t;

    // Widen a 16-bit signed value to accumulator width
    function automatic logic signed [ACC_W-1:0] sext_psum(input logic signed [PSUM_W-1:0] v);
        return {{(ACC_W-PSUM_W){v[PSUM_W-1]}}, v};
    endfunction

endpackage

// File: rtl/psum_accum_sat_24to16.sv
// Clamps a 24-bit signed accumulator into the 16-bit signed result range.
// Latency: combinational.
// Backpressure: none (pure function of its input).
module sat_24to16
    import psum_accum_pkg::*;
(
    input  logic signed [ACC_W-1:0]  i_acc,
    output logic signed [PSUM_W-1:0] o_sat
);

    // Clamp to the representable range, otherwise pass the low bits through
    always_comb begin
        if (i_acc > SAT_MAX) begin
            o_sat = SAT_MAX[PSUM_W-1:0];
        end else if (i_acc < SAT_MIN) begin
            o_sat = SAT_MIN[PSUM_W-1:0];
        end else begin
            o_sat = i_acc[PSUM_W-1:0];
        end
    end

endmodule

// File: rtl/psum_accum.sv
// Sums KTAPS products per neuron, optionally merges the prior psum from RAM, emits saturated result.
// Latency: last accepted tap -> neuron_rdy is 1 cycle (first plane) or 3 cycles (RAM merge).
// Backpressure: in_ready is high only in ACC; products offered while in_ready is low stay pending.
module psum_accum
    import psum_accum_pkg::*;
#(
    parameter  int KTAPS  = 9,
    parameter  int NPLANE = 16,
    localparam int ADDR_W = (NPLANE > 1) ? $clog2(NPLANE) : 1
)(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     first_plane,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [PSUM_W-1:0] prod,
    output logic                     ram_rd_en,
    output logic [ADDR_W-1:0]        ram_rd_addr,
    input  logic signed [PSUM_W-1:0] ram_rd_data,
    output logic signed [PSUM_W-1:0] din_acc,
    output logic                     neuron_rdy,
    output logic                     plane_rdy,
    output logic                     sel
);

    state_t                   r_state;
    state_t                   w_next;
    logic [ADDR_W-1:0]        r_n;
    logic [7:0]               r_t;
    logic signed [ACC_W-1:0]  r_acc;
    logic                     r_first;
    logic signed [PSUM_W-1:0] r_hold;
    logic signed [PSUM_W-1:0] w_sat;
    logic                     w_accept;
    logic                     w_last_tap;
    logic                     w_last_n;

    assign w_accept   = (r_state == ST_ACC) && in_valid;
    assign w_last_tap = (r_t == 8'(KTAPS - 1));
    assign w_last_n   = (r_n == ADDR_W'(NPLANE - 1));

    sat_24to16 u_sat (
        .i_acc (r_acc),
        .o_sat (w_sat)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state: a start outside IDLE (including during the final EMIT) is not looked at
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_next = ST_ACC;
            ST_ACC:   if (w_accept && w_last_tap) w_next = r_first ? ST_EMIT : ST_FETCH;
            ST_FETCH: w_next = ST_MERGE;
            ST_MERGE: w_next = ST_EMIT;
            ST_EMIT:  w_next = w_last_n ? ST_IDLE : ST_ACC;
            default:  w_next = ST_IDLE;
        endcase
    end

    // Outputs: in EMIT the fresh saturated value is shown directly, afterwards the held copy
    always_comb begin
        in_ready    = (r_state == ST_ACC);
        ram_rd_en   = (r_state == ST_FETCH);
        ram_rd_addr = r_n;
        neuron_rdy  = (r_state == ST_EMIT);
        plane_rdy   = (r_state == ST_EMIT) && w_last_n;
        sel         = (r_state != ST_IDLE);
        din_acc     = (r_state == ST_EMIT) ? w_sat : r_hold;
    end

    // Neuron index and tap counter; n only returns to 0 through a new start from IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_n     <= '0;
            r_t     <= '0;
            r_first <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_n     <= '0;
                        r_t     <= '0;
                        r_first <= first_plane;
                    end
                end
                ST_ACC: begin
                    if (w_accept) r_t <= r_t + 8'd1;
                end
                ST_EMIT: begin
                    if (!w_last_n) begin
                        r_n <= r_n + ADDR_W'(1);
                        r_t <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Accumulator: products in ACC, prior psum in MERGE (RAM data lands one cycle after FETCH)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else begin
            case (r_state)
                ST_IDLE:  if (start) r_acc <= '0;
                ST_ACC:   if (w_accept) r_acc <= r_acc + sext_psum(prod);
                ST_MERGE: r_acc <= r_acc + sext_psum(ram_rd_data);
                ST_EMIT:  if (!w_last_n) r_acc <= '0;
                default: begin
                end
            endcase
        end
    end

    // Keep the last emitted result on din_acc until the next EMIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold <= '0;
        end else if (r_state == ST_EMIT) begin
            r_hold <= w_sat;
        end
    end

endmodule

// File: tb/tb_psum_accum.sv
module tb_psum_accum;

    localparam int KTAPS  = 9;
    localparam int NPLANE = 16;
    localparam int ADDR_W = 4;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                start = 1'b0;
    logic                first_plane = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic signed [15:0]  prod = 16'sd0;
    logic                ram_rd_en;
    logic [ADDR_W-1:0]   ram_rd_addr;
    logic signed [15:0]  ram_rd_data = 16'sd0;
    logic signed [15:0]  din_acc;
    logic                neuron_rdy;
    logic                plane_rdy;
    logic                sel;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // monitor bookkeeping (written only by the monitor)
    int nidx = 0;
    int taps = 0;
    int last_acc_cyc = 0;
    int neuron_cnt = 0;
    int plane_cnt = 0;
    int rd_cnt = 0;

    // expectations set by the directed steps
    logic signed [15:0] exp_din = 16'sd0;
    int                 exp_lat = 1;
    logic signed [15:0] ram_val = 16'sd0;

    psum_accum #(.KTAPS(KTAPS), .NPLANE(NPLANE)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .first_plane (first_plane),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .prod        (prod),
        .ram_rd_en   (ram_rd_en),
        .ram_rd_addr (ram_rd_addr),
        .ram_rd_data (ram_rd_data),
        .din_acc     (din_acc),
        .neuron_rdy  (neuron_rdy),
        .plane_rdy   (plane_rdy),
        .sel         (sel)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // psum RAM: every location holds ram_val, read data valid one cycle after the strobe
    always @(posedge clk) if (ram_rd_en) ram_rd_data <= ram_val;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (!rst_n) begin
            nidx = 0;
            taps = 0;
        end else begin
            if (in_valid && in_ready) begin
                taps++;
                last_acc_cyc = cyc;
            end
            if (ram_rd_en) begin
                rd_cnt++;
                check("ram_rd_addr", 32'(ram_rd_addr), 32'(nidx));
            end
            if (neuron_rdy) begin
                neuron_cnt++;
                check("din_acc", din_acc, exp_din);
                check("taps_per_neuron", taps, KTAPS);
                check("latency", cyc - last_acc_cyc, exp_lat);
                check("plane_rdy_on_last", plane_rdy, nidx == NPLANE - 1);
                if (plane_rdy) begin
                    plane_cnt++;
                    nidx = 0;
                end else begin
                    nidx++;
                end
                taps = 0;
            end else begin
                check("plane_rdy_alone", plane_rdy, 1'b0);
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"}, in_ready, 1'b0);
        check({tag, "_ram_rd_en"}, ram_rd_en, 1'b0);
        check({tag, "_neuron_rdy"}, neuron_rdy, 1'b0);
        check({tag, "_plane_rdy"}, plane_rdy, 1'b0);
        check({tag, "_sel"}, sel, 1'b0);
        check({tag, "_din_acc"}, din_acc, 16'sd0);
        check({tag, "_ram_rd_addr"}, ram_rd_addr, 4'd0);
    endtask

    // One full plane; called at posedge+1 with the DUT idle
    task automatic run_plane(input logic fp, input logic signed [15:0] val,
                             input bit toggle, input bit mid_start);
        int target;
        int n0;
        int r0;
        target = plane_cnt + 1;
        n0 = neuron_cnt;
        r0 = rd_cnt;
        prod = val;
        in_valid = 1'b1;
        first_plane = fp;
        start = 1'b1;
        for (int i = 0; i < 3000 && plane_cnt < target; i++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (toggle) in_valid = ~in_valid;
            if (i == 20) check("sel_active", sel, 1'b1);
            if (mid_start && i == 40) begin
                start = 1'b1;
                first_plane = ~fp;
            end
        end
        in_valid = 1'b0;
        start = 1'b0;
        check("plane_done", plane_cnt, target);
        check("neurons_in_plane", neuron_cnt - n0, NPLANE);
        check("ram_reads", rd_cnt - r0, fp ? 0 : NPLANE);
        check("sel_after_plane", sel, 1'b0);
        check("in_ready_after_plane", in_ready, 1'b0);
        check("din_acc_held", din_acc, exp_din);
    endtask

    initial begin
        int n_before;

        // reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // first plane, unit products: 9 per neuron, 1-cycle latency
        exp_din = 16'sd9;
        exp_lat = 1;
        run_plane(1'b1, 16'sd1, 1'b0, 1'b0);

        // merge with prior psum 100: 9*2 + 100 = 118, 3-cycle latency
        ram_val = 16'sd100;
        exp_din = 16'sd118;
        exp_lat = 3;
        run_plane(1'b0, 16'sd2, 1'b0, 1'b0);

        // positive saturation: 9*32767 clamps to 32767
        exp_din = 16'sd32767;
        exp_lat = 1;
        run_plane(1'b1, 16'sd32767, 1'b0, 1'b0);

        // negative saturation: 9*-32768 clamps to -32768
        exp_din = 16'sh8000;
        exp_lat = 1;
        run_plane(1'b1, 16'sh8000, 1'b0, 1'b0);

        // in_valid toggling and a stray start mid-plane: 9*3 = 27, no RAM traffic
        exp_din = 16'sd27;
        exp_lat = 1;
        run_plane(1'b1, 16'sd3, 1'b1, 1'b1);

        // reset in the middle of neuron 5
        ram_val = 16'sd100;
        exp_din = 16'sd109;
        exp_lat = 3;
        prod = 16'sd1;
        in_valid = 1'b1;
        first_plane = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 2000 && !(nidx == 5 && taps == 4); i++) @(posedge clk);
        check("reached_n5_t4", (nidx == 5) && (taps == 4), 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        n_before = neuron_cnt;
        repeat (40) @(posedge clk);
        #1;
        check("no_pulse_after_reset", neuron_cnt - n_before, 0);
        check("in_ready_idle", in_ready, 1'b0);
        check("sel_idle", sel, 1'b0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        // restart: first read must be address 0, result 9*1 + 100 = 109
        run_plane(1'b0, 16'sd1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
